// File: rtl/nn_pkg.sv
// Shared types and defaults for the neuron-layer sequencing blocks.
package nn_pkg;

  // Phases of one layer pass: buffer a frame, broadcast it, collect results, hand off.
  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } seq_state_t;

  localparam int DATA_WIDTH_DEF = 8;

endpackage

// File: rtl/frame_buffer.sv
// Simple dual-port synchronous RAM holding one input frame.
// The read port has one cycle of latency. Contents are never cleared.
module frame_buffer #(
  parameter int DEPTH = 784,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rd_data_r;

  // Write from the fill side; registered read for the broadcast side.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/layer_sequencer.sv
// Sequences one fully-connected layer: buffers a frame, broadcasts it to all
// neurons as a gap-free burst, collects every neuron's output into a packed
// vector and hands that vector downstream under valid/ready.
module layer_sequencer
  import nn_pkg::*;
#(
  parameter int NUM_INPUTS     = 784,
  parameter int NUM_NEURONS    = 30,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH-1:0]             s_data,
  input  logic                              s_valid,
  output logic                              s_ready,
  output logic [DATA_WIDTH-1:0]             neuron_in,
  output logic                              neuron_in_valid,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] neuron_out,
  input  logic [NUM_NEURONS-1:0]            neuron_out_valid,
  output logic [NUM_NEURONS*DATA_WIDTH-1:0] layer_out,
  output logic                              layer_out_valid,
  input  logic                              layer_out_ready,
  output logic                              timeout_err,
  output logic                              busy
);

  localparam int AW = $clog2(NUM_INPUTS);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_INPUTS - 1);
  localparam logic [AW-1:0] ONE_A     = AW'(1);
  localparam logic [TW-1:0] LAST_TMO  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] ONE_T     = TW'(1);

  seq_state_t                        state_r;
  logic [AW-1:0]                     wr_cnt_r;
  logic [AW-1:0]                     rd_cnt_r;
  logic                              rd_active_r;
  logic                              rd_valid_r;
  logic [TW-1:0]                     tmo_cnt_r;
  logic [NUM_NEURONS-1:0]            got_r;
  logic                              s_ready_r;
  logic [DATA_WIDTH-1:0]             neuron_in_r;
  logic                              neuron_in_valid_r;
  logic [NUM_NEURONS*DATA_WIDTH-1:0] layer_out_r;
  logic                              layer_out_valid_r;
  logic                              timeout_err_r;

  logic                              accept_s;
  logic                              rd_en_s;
  logic [NUM_NEURONS-1:0]            new_s;
  logic [NUM_NEURONS-1:0]            got_next_s;
  logic                              all_got_s;
  logic [DATA_WIDTH-1:0]             rd_data_s;

  frame_buffer #(
    .DEPTH (NUM_INPUTS),
    .WIDTH (DATA_WIDTH),
    .AW    (AW)
  ) u_frame_buffer (
    .clk     (clk),
    .wr_en   (accept_s),
    .wr_addr (wr_cnt_r),
    .wr_data (s_data),
    .rd_en   (rd_en_s),
    .rd_addr (rd_cnt_r),
    .rd_data (rd_data_s)
  );

  // Handshake, read issue and newly-arrived neuron results (only looked at in WAIT).
  always_comb begin
    accept_s = s_valid & s_ready_r;
    rd_en_s  = 1'b0;
    new_s    = {NUM_NEURONS{1'b0}};
    if (state_r == STREAM) begin
      rd_en_s = rd_active_r;
    end else begin
      rd_en_s = 1'b0;
    end
    if (state_r == WAIT) begin
      new_s = neuron_out_valid & ~got_r;
    end else begin
      new_s = {NUM_NEURONS{1'b0}};
    end
    got_next_s = got_r | new_s;
    all_got_s  = &got_next_s;
  end

  // Sequencer FSM with counters, capture mask and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r           <= FILL;
      wr_cnt_r          <= {AW{1'b0}};
      rd_cnt_r          <= {AW{1'b0}};
      rd_active_r       <= 1'b0;
      rd_valid_r        <= 1'b0;
      tmo_cnt_r         <= {TW{1'b0}};
      got_r             <= {NUM_NEURONS{1'b0}};
      s_ready_r         <= 1'b0;
      neuron_in_r       <= {DATA_WIDTH{1'b0}};
      neuron_in_valid_r <= 1'b0;
      layer_out_r       <= {(NUM_NEURONS*DATA_WIDTH){1'b0}};
      layer_out_valid_r <= 1'b0;
      timeout_err_r     <= 1'b0;
    end else begin
      // Two-stage broadcast pipe: RAM read register, then output register.
      rd_valid_r        <= rd_en_s;
      neuron_in_valid_r <= rd_valid_r;
      if (rd_valid_r) begin
        neuron_in_r <= rd_data_s;
      end

      case (state_r)
        FILL: begin
          if (accept_s && (wr_cnt_r == LAST_ADDR)) begin
            s_ready_r   <= 1'b0;
            rd_cnt_r    <= {AW{1'b0}};
            rd_active_r <= 1'b1;
            state_r     <= STREAM;
          end else begin
            s_ready_r <= 1'b1;
            if (accept_s) begin
              wr_cnt_r <= wr_cnt_r + ONE_A;
            end
          end
        end

        STREAM: begin
          if (rd_en_s) begin
            if (rd_cnt_r == LAST_ADDR) begin
              rd_active_r <= 1'b0;
            end else begin
              rd_cnt_r <= rd_cnt_r + ONE_A;
            end
          end
          // Burst tail leaves the output register on this edge.
          if (neuron_in_valid_r && !rd_valid_r) begin
            tmo_cnt_r <= {TW{1'b0}};
            state_r   <= WAIT;
          end
        end

        WAIT: begin
          for (int k = 0; k < NUM_NEURONS; k++) begin
            if (new_s[k]) begin
              layer_out_r[k*DATA_WIDTH +: DATA_WIDTH] <= neuron_out[k*DATA_WIDTH +: DATA_WIDTH];
            end
          end
          got_r <= got_next_s;
          // A completing capture beats a simultaneous timeout.
          if (all_got_s) begin
            layer_out_valid_r <= 1'b1;
            timeout_err_r     <= 1'b0;
            state_r           <= DONE;
          end else if (tmo_cnt_r == LAST_TMO) begin
            layer_out_valid_r <= 1'b1;
            timeout_err_r     <= 1'b1;
            state_r           <= DONE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + ONE_T;
          end
        end

        DONE: begin
          if (layer_out_valid_r && layer_out_ready) begin
            layer_out_valid_r <= 1'b0;
            timeout_err_r     <= 1'b0;
            got_r             <= {NUM_NEURONS{1'b0}};
            wr_cnt_r          <= {AW{1'b0}};
            s_ready_r         <= 1'b1;
            state_r           <= FILL;
          end
        end

        default: begin
          state_r <= FILL;
        end
      endcase
    end
  end

  assign s_ready         = s_ready_r;
  assign neuron_in       = neuron_in_r;
  assign neuron_in_valid = neuron_in_valid_r;
  assign layer_out       = layer_out_r;
  assign layer_out_valid = layer_out_valid_r;
  assign timeout_err     = timeout_err_r;
  assign busy            = (state_r != FILL);

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed-plus-random bench for layer_sequencer with a 4-neuron layer.
// The reference model holds the frame as an array and the expected layer
// vector per neuron, and derives burst timing and WAIT completion from the
// arrival schedule with plain arithmetic.
module tb_layer_sequencer;

  localparam int NI = 784;
  localparam int NN = 4;
  localparam int DW = 8;
  localparam int TO = 64;

  logic               clk = 1'b0;
  logic               rst;
  logic [DW-1:0]      s_data;
  logic               s_valid;
  logic               s_ready;
  logic [DW-1:0]      neuron_in;
  logic               neuron_in_valid;
  logic [NN*DW-1:0]   neuron_out;
  logic [NN-1:0]      neuron_out_valid;
  logic [NN*DW-1:0]   layer_out;
  logic               layer_out_valid;
  logic               layer_out_ready;
  logic               timeout_err;
  logic               busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] frame_m [NI];
  logic [7:0] lay_m   [NN];
  int         arr_t   [NN];
  logic [7:0] arr_v   [NN];
  logic       exp_terr;

  layer_sequencer #(
    .NUM_INPUTS     (NI),
    .NUM_NEURONS    (NN),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .s_data           (s_data),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .neuron_in        (neuron_in),
    .neuron_in_valid  (neuron_in_valid),
    .neuron_out       (neuron_out),
    .neuron_out_valid (neuron_out_valid),
    .layer_out        (layer_out),
    .layer_out_valid  (layer_out_valid),
    .layer_out_ready  (layer_out_ready),
    .timeout_err      (timeout_err),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NN*DW-1:0] lay_vec();
    logic [NN*DW-1:0] v;
    for (int k = 0; k < NN; k++) v[k*DW +: DW] = lay_m[k];
    return v;
  endfunction

  // Load a frame through the upstream port; ends just after the last accept edge.
  task automatic fill_frame(input bit gaps, input bit rnd);
    int i;
    int c;
    for (int j = 0; j < NI; j++) frame_m[j] = rnd ? 8'($urandom) : 8'(j % 256);
    i = 0;
    c = 0;
    while (i < NI && c < 4 * NI) begin
      s_valid = gaps ? (c % 3 != 2) : 1'b1;
      s_data  = frame_m[i];
      chk("s_ready_fill", s_ready, 1'b1);
      if (s_valid) i++;
      c++;
      step();
    end
    chk("fill_budget", (i == NI), 1'b1);
    s_valid = 1'b0;
    chk("s_ready_after_last", s_ready, 1'b0);
    chk("busy_after_last", busy, 1'b1);
    chk("nv_after_last", neuron_in_valid, 1'b0);
  endtask

  // Burst starts two edges after the last accept and lasts exactly NI cycles.
  task automatic stream_check(input bit stall);
    if (stall) begin
      s_valid = 1'b1;
      s_data  = 8'hEE;
    end
    step();
    chk("nv_one_cycle", neuron_in_valid, 1'b0);
    if (stall) chk("s_ready_stall", s_ready, 1'b0);
    step();
    for (int i = 0; i < NI; i++) begin
      chk("nv_burst", neuron_in_valid, 1'b1);
      chk("neuron_in", neuron_in, frame_m[i]);
      if (stall) chk("s_ready_stall", s_ready, 1'b0);
      step();
    end
    s_valid = 1'b0;
    chk("nv_end", neuron_in_valid, 1'b0);
    chk("neuron_in_hold", neuron_in, frame_m[NI-1]);
    chk("busy_wait", busy, 1'b1);
    chk("layer_out_pre", layer_out, lay_vec());
    chk("lov_pre", layer_out_valid, 1'b0);
  endtask

  // Drive the arrival schedule in WAIT; arr_t = -1 means the neuron never answers.
  task automatic wait_phase();
    int done_t;
    int mx;
    bit all_in;
    all_in = 1'b1;
    mx = 0;
    for (int k = 0; k < NN; k++) begin
      if (arr_t[k] < 0 || arr_t[k] >= TO) all_in = 1'b0;
      else if (arr_t[k] > mx) mx = arr_t[k];
    end
    done_t   = all_in ? mx + 1 : TO;
    exp_terr = !all_in;
    for (int t = 0; t < done_t; t++) begin
      for (int k = 0; k < NN; k++) begin
        neuron_out_valid[k] = (arr_t[k] >= 0) && (t >= arr_t[k]);
        neuron_out[k*DW +: DW] = (t == arr_t[k]) ? arr_v[k] : 8'($urandom);
        if (t == arr_t[k]) lay_m[k] = arr_v[k];
      end
      step();
      if (t + 1 < done_t) chk("lov_in_wait", layer_out_valid, 1'b0);
    end
    chk("lov_done", layer_out_valid, 1'b1);
    chk("terr_done", timeout_err, exp_terr);
    chk("layer_out", layer_out, lay_vec());
    chk("busy_done", busy, 1'b1);
    chk("s_ready_done", s_ready, 1'b0);
  endtask

  // Hold back-pressure, check stability, then complete the handshake.
  task automatic handoff(input int hold);
    for (int j = 0; j < hold; j++) begin
      neuron_out = NN*DW'($urandom);
      step();
      chk("lov_hold", layer_out_valid, 1'b1);
      chk("terr_hold", timeout_err, exp_terr);
      chk("layer_out_hold", layer_out, lay_vec());
    end
    layer_out_ready = 1'b1;
    step();
    layer_out_ready = 1'b0;
    chk("lov_after_hs", layer_out_valid, 1'b0);
    chk("terr_after_hs", timeout_err, 1'b0);
    chk("busy_after_hs", busy, 1'b0);
    chk("layer_out_after_hs", layer_out, lay_vec());
    step();
    chk("s_ready_after_hs", s_ready, 1'b1);
  endtask

  initial begin
    rst              = 1'b0;
    s_valid          = 1'b0;
    s_data           = 8'h00;
    neuron_out       = {(NN*DW){1'b0}};
    neuron_out_valid = {NN{1'b0}};
    layer_out_ready  = 1'b0;
    for (int k = 0; k < NN; k++) lay_m[k] = 8'h00;

    // Reset state
    repeat (3) step();
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_neuron_in", neuron_in, 8'h00);
    chk("rst_nv", neuron_in_valid, 1'b0);
    chk("rst_layer_out", layer_out, 32'h0);
    chk("rst_lov", layer_out_valid, 1'b0);
    chk("rst_terr", timeout_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b1;
    step();
    chk("s_ready_release", s_ready, 1'b1);

    // Frame A: gap-free ramp, staggered neuron outputs
    fill_frame(1'b0, 1'b0);
    stream_check(1'b0);
    arr_t = '{5, 9, 3, 5};
    arr_v = '{8'h11, 8'h7F, 8'h5A, 8'h22};
    wait_phase();
    chk("stagger_vector", layer_out, 32'h225A7F11);
    handoff(3);

    // Frame B: upstream gaps, stall during broadcast, stale outvalid levels, random results
    neuron_out = NN*DW'($urandom);
    fill_frame(1'b1, 1'b1);
    neuron_out = NN*DW'($urandom);
    stream_check(1'b1);
    for (int k = 0; k < NN; k++) begin
      arr_t[k] = int'($urandom_range(0, 20));
      arr_v[k] = 8'($urandom);
    end
    wait_phase();
    handoff(20);

    // Frame C: reset in the middle of the broadcast
    fill_frame(1'b0, 1'b1);
    step();
    repeat (12) step();
    chk("nv_mid_stream", neuron_in_valid, 1'b1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int k = 0; k < NN; k++) lay_m[k] = 8'h00;
    chk("abort_nv", neuron_in_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_neuron_in", neuron_in, 8'h00);
    chk("abort_s_ready", s_ready, 1'b0);
    chk("abort_layer_out", layer_out, lay_vec());
    step();
    chk("abort_s_ready_rise", s_ready, 1'b1);

    // Frame D: neuron 1 never answers
    neuron_out_valid = {NN{1'b0}};
    fill_frame(1'b0, 1'b1);
    stream_check(1'b0);
    arr_t = '{4, -1, 20, 0};
    for (int k = 0; k < NN; k++) arr_v[k] = 8'($urandom_range(1, 255));
    wait_phase();
    chk("timeout_slice1", layer_out[DW +: DW], 8'h00);
    handoff(2);

    // Frame E: last capture lands on the final WAIT cycle
    neuron_out_valid = {NN{1'b0}};
    fill_frame(1'b1, 1'b1);
    stream_check(1'b0);
    arr_t = '{TO - 1, 10, 0, 30};
    for (int k = 0; k < NN; k++) arr_v[k] = 8'($urandom);
    wait_phase();
    handoff(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
